// File: rtl/mips16_pkg.sv
// Shared MIPS-16 definitions: datapath widths and ALU operation codes.
// No logic of its own; imported by the decoder and the execute stage.
// Not applicable: package only.
package mips16_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 3;

    // ALU operation codes as carried on ALUCtrl from decode
    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_NOR = 3'b101,
        ALU_SLT = 3'b110,
        ALU_SLL = 3'b111
    } alu_op_t;

endpackage

// File: rtl/alu16.sv
// 16-bit ALU: add/sub (wrapping), logic ops, signed set-less-than, shift-left.
// Latency: purely combinational.
// Backpressure: none; output follows inputs within the cycle.
module alu16
    import mips16_pkg::*;
(
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y,
    output logic              zero
);

    // Operation select; SLT compares as two's complement, SLL uses b[3:0]
    always_comb begin
        y = '0;
        case (alu_op_t'(op))
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_NOR: y = ~(a | b);
            ALU_SLT: y = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLL: y = a << b[3:0];
        endcase
    end

    // Zero flag on the final result
    always_comb begin
        zero = (y == '0);
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, destination select, EX/MEM register.
// Latency: one cycle from ID/EX inputs to the _m outputs.
// Backpressure: stall_m holds EX/MEM; flush_x or !valid_x loads a bubble.
module ex_stage
    import mips16_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        ALUCtrl_x,
    input  logic              reg_dst_x,
    input  logic              mem_to_reg_x,
    input  logic              mem_write_x,
    input  logic              alu_src_x,
    input  logic              reg_write_x,
    input  logic              valid_x,
    input  logic [DATA_W-1:0] rdata1_x,
    input  logic [DATA_W-1:0] rdata2_x,
    input  logic [DATA_W-1:0] sign_ext_imm_x,
    input  logic [REG_AW-1:0] rs_x,
    input  logic [REG_AW-1:0] rt_x,
    input  logic [REG_AW-1:0] rd_x,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              stall_m,
    input  logic              flush_x,
    output logic [DATA_W-1:0] alu_result_m,
    output logic [DATA_W-1:0] store_data_m,
    output logic [REG_AW-1:0] waddr_m,
    output logic              mem_to_reg_m,
    output logic              mem_write_m,
    output logic              reg_write_m,
    output logic              valid_m,
    output logic              zero_m
);

    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] fwd_rt;
    logic [DATA_W-1:0] opb;
    logic [DATA_W-1:0] alu_y;
    logic              alu_zero;
    logic [REG_AW-1:0] waddr;
    logic              exm_fwd_ok;

    // A load in EX/MEM has no data yet; the hazard unit bubbles load-use,
    // so only committed ALU results are offered as a forwarding source.
    assign exm_fwd_ok = valid_m && reg_write_m && !mem_to_reg_m;

    // Forward rs: EX/MEM beats MEM/WB; index 0 is never forwarded
    always_comb begin
        opa = rdata1_x;
        if (rs_x != '0) begin
            if (exm_fwd_ok && (waddr_m == rs_x)) begin
                opa = alu_result_m;
            end else if (wb_reg_write && (wb_waddr == rs_x)) begin
                opa = wb_wdata;
            end
        end
    end

    // Forward rt with the same priority; feeds both ALU B and store data
    always_comb begin
        fwd_rt = rdata2_x;
        if (rt_x != '0) begin
            if (exm_fwd_ok && (waddr_m == rt_x)) begin
                fwd_rt = alu_result_m;
            end else if (wb_reg_write && (wb_waddr == rt_x)) begin
                fwd_rt = wb_wdata;
            end
        end
    end

    // ALU B source and destination register select
    always_comb begin
        opb   = alu_src_x ? sign_ext_imm_x : fwd_rt;
        waddr = reg_dst_x ? rd_x : rt_x;
    end

    alu16 u_alu (
        .op   (ALUCtrl_x),
        .a    (opa),
        .b    (opb),
        .y    (alu_y),
        .zero (alu_zero)
    );

    // EX/MEM register: stall holds, flush/invalid loads a zeroed bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_result_m <= '0;
            store_data_m <= '0;
            waddr_m      <= '0;
            mem_to_reg_m <= 1'b0;
            mem_write_m  <= 1'b0;
            reg_write_m  <= 1'b0;
            valid_m      <= 1'b0;
            zero_m       <= 1'b0;
        end else if (stall_m) begin
            alu_result_m <= alu_result_m;
            store_data_m <= store_data_m;
            waddr_m      <= waddr_m;
            mem_to_reg_m <= mem_to_reg_m;
            mem_write_m  <= mem_write_m;
            reg_write_m  <= reg_write_m;
            valid_m      <= valid_m;
            zero_m       <= zero_m;
        end else if (flush_x || !valid_x) begin
            alu_result_m <= '0;
            store_data_m <= '0;
            waddr_m      <= '0;
            mem_to_reg_m <= 1'b0;
            mem_write_m  <= 1'b0;
            reg_write_m  <= 1'b0;
            valid_m      <= 1'b0;
            zero_m       <= 1'b0;
        end else begin
            alu_result_m <= alu_y;
            store_data_m <= fwd_rt;
            waddr_m      <= waddr;
            mem_to_reg_m <= mem_to_reg_x;
            mem_write_m  <= mem_write_x;
            reg_write_m  <= reg_write_x;
            valid_m      <= 1'b1;
            zero_m       <= alu_zero;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed cases then randomized traffic vs a reference model.
// Latency: model predicts _m outputs one edge after the inputs are applied.
// Backpressure: random stall_m / flush_x / valid_x exercise hold and bubble.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  ALUCtrl_x;
    logic        reg_dst_x, mem_to_reg_x, mem_write_x, alu_src_x, reg_write_x, valid_x;
    logic [15:0] rdata1_x, rdata2_x, sign_ext_imm_x;
    logic [2:0]  rs_x, rt_x, rd_x;
    logic        wb_reg_write;
    logic [2:0]  wb_waddr;
    logic [15:0] wb_wdata;
    logic        stall_m, flush_x;
    logic [15:0] alu_result_m, store_data_m;
    logic [2:0]  waddr_m;
    logic        mem_to_reg_m, mem_write_m, reg_write_m, valid_m, zero_m;

    int checks   = 0;
    int failures = 0;

    // Reference EX/MEM contents; data fields are only meaningful after a real capture
    logic [15:0] m_res, m_sd;
    logic [2:0]  m_wa;
    logic        m_mtr, m_mw, m_rw, m_valid, m_zero, m_known;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ALUCtrl_x      (ALUCtrl_x),
        .reg_dst_x      (reg_dst_x),
        .mem_to_reg_x   (mem_to_reg_x),
        .mem_write_x    (mem_write_x),
        .alu_src_x      (alu_src_x),
        .reg_write_x    (reg_write_x),
        .valid_x        (valid_x),
        .rdata1_x       (rdata1_x),
        .rdata2_x       (rdata2_x),
        .sign_ext_imm_x (sign_ext_imm_x),
        .rs_x           (rs_x),
        .rt_x           (rt_x),
        .rd_x           (rd_x),
        .wb_reg_write   (wb_reg_write),
        .wb_waddr       (wb_waddr),
        .wb_wdata       (wb_wdata),
        .stall_m        (stall_m),
        .flush_x        (flush_x),
        .alu_result_m   (alu_result_m),
        .store_data_m   (store_data_m),
        .waddr_m        (waddr_m),
        .mem_to_reg_m   (mem_to_reg_m),
        .mem_write_m    (mem_write_m),
        .reg_write_m    (reg_write_m),
        .valid_m        (valid_m),
        .zero_m         (zero_m)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Arithmetic reference for the ALU, written with plain integer maths
    function automatic logic [15:0] alu_ref(input logic [2:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
        longint ua = a;
        longint ub = b;
        longint sa = (ua >= 32768) ? ua - 65536 : ua;
        longint sb = (ub >= 32768) ? ub - 65536 : ub;
        longint r;
        case (op)
            3'd0:    r = (ua + ub) % 65536;
            3'd1:    r = (ua - ub + 65536) % 65536;
            3'd2:    r = ua & ub;
            3'd3:    r = ua | ub;
            3'd4:    r = ua ^ ub;
            3'd5:    r = 65535 - (ua | ub);
            3'd6:    r = (sa < sb) ? 1 : 0;
            default: r = (ua * (longint'(1) << (ub % 16))) % 65536;
        endcase
        return r[15:0];
    endfunction

    // Value the instruction in EX would read for register idx
    function automatic logic [15:0] operand(input logic [2:0] idx, input logic [15:0] rf);
        if (idx == 3'd0) return rf;
        if (m_valid && m_rw && !m_mtr && m_wa == idx) return m_res;
        if (wb_reg_write && wb_waddr == idx) return wb_wdata;
        return rf;
    endfunction

    task automatic model_reset();
        m_res = '0; m_sd = '0; m_wa = '0;
        m_mtr = 0; m_mw = 0; m_rw = 0; m_valid = 0; m_zero = 0; m_known = 1;
    endtask

    task automatic compare_all(input string where);
        chk({where, ".valid_m"},      valid_m,      m_valid);
        chk({where, ".reg_write_m"},  reg_write_m,  m_rw);
        chk({where, ".mem_write_m"},  mem_write_m,  m_mw);
        chk({where, ".mem_to_reg_m"}, mem_to_reg_m, m_mtr);
        if (m_known) begin
            chk({where, ".alu_result_m"}, alu_result_m, m_res);
            chk({where, ".store_data_m"}, store_data_m, m_sd);
            chk({where, ".waddr_m"},      waddr_m,      m_wa);
            chk({where, ".zero_m"},       zero_m,       m_zero);
        end
    endtask

    // Predict the next EX/MEM contents, take one edge, then compare
    task automatic step(input string where);
        logic [15:0] a, rt_val, res;
        logic        hold, bubble;
        a      = operand(rs_x, rdata1_x);
        rt_val = operand(rt_x, rdata2_x);
        res    = alu_ref(ALUCtrl_x, a, alu_src_x ? sign_ext_imm_x : rt_val);
        hold   = stall_m;
        bubble = flush_x || !valid_x;
        @(posedge clk);
        #1;
        if (!hold) begin
            if (bubble) begin
                m_valid = 0; m_rw = 0; m_mw = 0; m_mtr = 0; m_known = 0;
            end else begin
                m_res = res; m_sd = rt_val; m_zero = (res == 16'h0000);
                m_wa = reg_dst_x ? rd_x : rt_x;
                m_mtr = mem_to_reg_x; m_mw = mem_write_x; m_rw = reg_write_x;
                m_valid = 1; m_known = 1;
            end
        end
        compare_all(where);
    endtask

    task automatic set_instr(input logic [2:0] op, input logic [15:0] r1, input logic [15:0] r2,
                             input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                             input logic rw, input logic mtr);
        ALUCtrl_x = op; rdata1_x = r1; rdata2_x = r2; sign_ext_imm_x = 16'h0040;
        rs_x = rs; rt_x = rt; rd_x = rd;
        reg_dst_x = 1; alu_src_x = 0; reg_write_x = rw; mem_to_reg_x = mtr; mem_write_x = 0;
        valid_x = 1;
    endtask

    initial begin
        logic [15:0] held;
        rst_n = 0;
        stall_m = 0; flush_x = 0;
        wb_reg_write = 0; wb_waddr = 0; wb_wdata = 0;
        set_instr(3'd0, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
        valid_x = 0;
        model_reset();
        #12;
        chk("reset.alu_result_m", alu_result_m, 16'h0000);
        chk("reset.valid_m", valid_m, 1'b0);
        chk("reset.zero_m", zero_m, 1'b0);
        compare_all("reset");
        rst_n = 1;

        // Basic ADD 5 + 3
        set_instr(3'd0, 16'h0005, 16'h0003, 3'd1, 3'd2, 3'd5, 1'b1, 1'b0);
        step("add");
        chk("add.lit_result", alu_result_m, 16'h0008);
        chk("add.lit_valid", valid_m, 1'b1);
        chk("add.lit_zero", zero_m, 1'b0);

        // Signed SLT and wrapping SUB
        set_instr(3'd6, 16'hFFFF, 16'h0001, 3'd1, 3'd2, 3'd5, 1'b1, 1'b0);
        step("slt");
        chk("slt.lit_result", alu_result_m, 16'h0001);
        set_instr(3'd1, 16'h0000, 16'h0001, 3'd1, 3'd2, 3'd6, 1'b1, 1'b0);
        step("sub");
        chk("sub.lit_result", alu_result_m, 16'hFFFF);

        // EX/MEM wins over MEM/WB for the same index
        set_instr(3'd0, 16'h00A0, 16'h000A, 3'd1, 3'd2, 3'd3, 1'b1, 1'b0);
        step("fwd_prod");
        set_instr(3'd3, 16'h1111, 16'h0000, 3'd3, 3'd0, 3'd4, 1'b1, 1'b0);
        wb_reg_write = 1; wb_waddr = 3'd3; wb_wdata = 16'h0055;
        step("fwd_prio");
        chk("fwd_prio.lit", alu_result_m, 16'h00AA);

        // Index 0 never forwarded
        set_instr(3'd0, 16'h1234, 16'h0000, 3'd1, 3'd2, 3'd0, 1'b1, 1'b0);
        wb_reg_write = 0;
        step("r0_prod");
        set_instr(3'd3, 16'h0123, 16'h0000, 3'd0, 3'd0, 3'd4, 1'b1, 1'b0);
        wb_reg_write = 1; wb_waddr = 3'd0; wb_wdata = 16'h0055;
        step("r0_use");
        chk("r0.lit", alu_result_m, 16'h0123);

        // Load in EX/MEM is skipped; MEM/WB supplies the value
        set_instr(3'd0, 16'h0040, 16'h0000, 3'd1, 3'd0, 3'd4, 1'b1, 1'b1);
        wb_reg_write = 0;
        step("load");
        set_instr(3'd3, 16'h0777, 16'h0000, 3'd4, 3'd0, 3'd5, 1'b1, 1'b0);
        wb_reg_write = 1; wb_waddr = 3'd4; wb_wdata = 16'h0055;
        step("load_use");
        chk("load_use.lit", alu_result_m, 16'h0055);
        wb_reg_write = 0;

        // Stall for three edges holds everything
        held = alu_result_m;
        set_instr(3'd4, 16'hF0F0, 16'h0F0F, 3'd1, 3'd2, 3'd6, 1'b1, 1'b0);
        stall_m = 1;
        for (int i = 0; i < 3; i++) begin
            step("stall");
            chk("stall.lit_hold", alu_result_m, held);
        end
        stall_m = 0;
        step("stall_release");
        chk("stall_release.lit", alu_result_m, 16'hFFFF);

        // Flush of a valid ADD
        set_instr(3'd0, 16'h0001, 16'h0001, 3'd1, 3'd2, 3'd3, 1'b1, 1'b0);
        mem_write_x = 1;
        flush_x = 1;
        step("flush");
        chk("flush.lit_valid", valid_m, 1'b0);
        flush_x = 0; mem_write_x = 0;

        // Flush during a stall lands on the first free edge
        step("pre_fs");
        stall_m = 1; flush_x = 1;
        step("fs_stalled");
        chk("fs_stalled.lit_valid", valid_m, 1'b1);
        stall_m = 0;
        step("fs_applied");
        chk("fs_applied.lit_valid", valid_m, 1'b0);
        flush_x = 0;

        // Reset between edges while valid_m=1
        step("pre_rst");
        #2;
        rst_n = 0;
        #1;
        model_reset();
        compare_all("midrst");
        chk("midrst.lit_valid", valid_m, 1'b0);
        @(negedge clk);
        rst_n = 1;
        set_instr(3'd0, 16'h0100, 16'h0023, 3'd1, 3'd2, 3'd7, 1'b1, 1'b0);
        step("post_rst");
        chk("post_rst.lit", alu_result_m, 16'h0123);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            ALUCtrl_x      = 3'($urandom_range(0, 7));
            rdata1_x       = 16'($urandom);
            rdata2_x       = ($urandom_range(0, 3) == 0) ? rdata1_x : 16'($urandom);
            sign_ext_imm_x = 16'($urandom);
            rs_x           = 3'($urandom_range(0, 3));
            rt_x           = 3'($urandom_range(0, 3));
            rd_x           = 3'($urandom_range(0, 3));
            reg_dst_x      = 1'($urandom);
            alu_src_x      = ($urandom_range(0, 3) == 0);
            reg_write_x    = ($urandom_range(0, 3) != 0);
            mem_to_reg_x   = ($urandom_range(0, 4) == 0);
            mem_write_x    = ($urandom_range(0, 4) == 0);
            valid_x        = ($urandom_range(0, 6) != 0);
            wb_reg_write   = 1'($urandom);
            wb_waddr       = 3'($urandom_range(0, 3));
            wb_wdata       = 16'($urandom);
            stall_m        = ($urandom_range(0, 4) == 0);
            flush_x        = ($urandom_range(0, 9) == 0);
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the pipelined MIPS-16 core: the consumer of the ID/EX pipeline register outputs. It resolves operand forwarding, performs the ALU operation, selects the destination register, and captures the result and surviving control bits into the EX/MEM pipeline register. It supports stall (hold) and flush (bubble) from the hazard logic.

## Interface
- DATA_W, 16, datapath width
- REG_AW, 3, register index width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- ALUCtrl_x  in  3  ALU operation code
- reg_dst_x, mem_to_reg_x, mem_write_x, alu_src_x, reg_write_x  in  1 each  control bits from ID/EX
- valid_x  in  1  ID/EX holds a real instruction
- rdata1_x, rdata2_x, sign_ext_imm_x  in  16 each  operands and immediate
- rs_x, rt_x, rd_x  in  3 each  register indices
- wb_reg_write, wb_waddr[2:0], wb_wdata[15:0]  in  MEM/WB write-back forwarding source
- stall_m  in  1  hold EX/MEM contents
- flush_x  in  1  squash the instruction currently in EX
- alu_result_m  out  16  registered ALU result (memory address for loads/stores)
- store_data_m  out  16  registered forwarded rt operand
- waddr_m  out  3  registered destination index
- mem_to_reg_m, mem_write_m, reg_write_m, valid_m, zero_m  out  1 each  registered control bits and zero flag

## Operation
- ALU codes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOR, 110 SLT (signed, result 16'h0001/16'h0000), 111 SLL (A << B[3:0]).
- ADD/SUB wrap modulo 2^16. No overflow trap.
- Forward A (rs) and forward B (rt) use the same priority:
  1. EX/MEM: valid_m && reg_write_m && !mem_to_reg_m && waddr_m==idx && idx!=0 -> alu_result_m.
  2. MEM/WB: wb_reg_write && wb_waddr==idx && idx!=0 -> wb_wdata.
  3. Otherwise rdata1_x / rdata2_x.
- Register 0 is hardwired zero. Index 0 is never forwarded.
- A load in EX/MEM is not a forwarding source. The hazard unit guarantees a load-use bubble.
- ALU B = alu_src_x ? sign_ext_imm_x : forwarded rt. store_data_m always takes forwarded rt.
- waddr = reg_dst_x ? rd_x : rt_x.
- zero_m = (ALU result == 0).
- Each clock edge, applied in priority order:
  1. stall_m: all _m outputs hold.
  2. flush_x or !valid_x: bubble is loaded. valid_m, reg_write_m, mem_write_m and mem_to_reg_m go to 0. Data outputs are don't-care; the implementation drives 0.
  3. Otherwise: capture the computed values with valid_m=1.
- While stall_m is asserted, the hazard unit holds ID/EX and flush_x. A flush asserted during a stall takes effect on the first non-stalled edge.

## Timing
- Reset (async assert, sync release): all outputs are 0, valid_m=0.
- Reset mid-operation discards the in-flight EX/MEM contents immediately.
- Latency: one cycle from the ID/EX outputs to the _m outputs. The ALU and forwarding muxes are purely combinational within the cycle.
- Forwarding from alu_result_m sees the value registered on the previous edge, which gives back-to-back dependent ALU ops with zero bubbles.
- A stall of N cycles holds the _m outputs for exactly N edges.
- Simultaneous matches on EX/MEM and MEM/WB for the same index: EX/MEM wins.

## Structure
- Shared package (mips16_pkg): ALU opcode constants, DATA_W, REG_AW. The decoder and this block import it.
- Sub-module alu16: purely combinational. Inputs are op, a and b; outputs are y and zero.
- ex_stage owns the forwarding muxes, dest select and EX/MEM register.

## Test plan
- Basic ADD: ADD, rdata1=16'h0005, rdata2=16'h0003, alu_src=0 -> next edge alu_result_m=16'h0008, valid_m=1, reg_write_m=1, zero_m=0.
- SLT signed: SLT with A=16'hFFFF, B=16'h0001 -> alu_result_m=16'h0001. SUB 16'h0000-16'h0001 -> 16'hFFFF (wrap).
- Forwarding priority: EX/MEM (rd=3, result 16'h00AA) and MEM/WB (waddr=3, data 16'h0055) both match rs=3 -> A=16'h00AA.
- Forwarding exclusions:
  - rs=0 with both sources writing index 0 -> A = rdata1_x.
  - EX/MEM holding a load -> MEM/WB value used.
- Stall/flush:
  - stall_m high for 3 cycles -> _m outputs unchanged for 3 edges.
  - flush_x with a valid ADD -> valid_m=0, reg_write_m=0, mem_write_m=0.
  - flush_x during stall -> applied on the first non-stalled edge.
- Reset mid-operation: assert rst_n=0 between edges while valid_m=1 -> all outputs 0 immediately. After release, the first instruction captures normally.
